// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, command opcodes, master FSM
// states, IR opcodes and the TAP transition table used by master and TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } jtag_state_t;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IR_SCAN  = 2'd1,
    OP_DR_SCAN  = 2'd2,
    OP_RUN_IDLE = 2'd3
  } jtag_cmd_op_t;

  typedef enum logic [2:0] {
    M_INIT,
    M_IDLE,
    M_HDR,
    M_SHIFT,
    M_TRL,
    M_DONE
  } jtag_mstate_t;

  localparam int          IR_LEN       = 6;
  localparam logic [5:0]  IR_BYPASS    = 6'h3F;
  localparam logic [5:0]  IR_IDCODE    = 6'h01;
  localparam logic [5:0]  IR_DMI       = 6'h21;
  localparam logic [5:0]  IR_SAMPLE    = 6'h00;
  localparam logic [31:0] IDCODE_VALUE = 32'h1BEEF001;

  // The reset sequence is five tms=1 bits followed by one tms=0 bit.
  localparam logic [4:0]  RESET_LAST_BIT = 5'd5;

  // IEEE 1149.1 TAP controller transition table.
  function automatic jtag_state_t jtag_next_state(input jtag_state_t state, input logic tms);
    jtag_state_t nxt;
    nxt = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        nxt = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

  // Index of the last header bit for each command that walks a header.
  function automatic logic [4:0] jtag_hdr_last(input jtag_cmd_op_t op);
    logic [4:0] last;
    case (op)
      OP_RESET:   last = 5'd5;
      OP_IR_SCAN: last = 5'd3;
      default:    last = 5'd2;
    endcase
    return last;
  endfunction

  // tms value of the bit at a given position of the master's bit stream.
  function automatic logic jtag_pos_tms(input jtag_mstate_t st, input logic [4:0] cnt,
                                        input jtag_cmd_op_t op, input logic [4:0] lenM1);
    logic t;
    t = 1'b0;
    case (st)
      M_INIT:  t = (cnt < RESET_LAST_BIT);
      M_HDR: begin
        case (op)
          OP_RESET:   t = (cnt < 5'd5);
          OP_IR_SCAN: t = (cnt < 5'd2);
          default:    t = (cnt < 5'd1);
        endcase
      end
      M_SHIFT: t = (op != OP_RUN_IDLE) && (cnt == lenM1);
      M_TRL:   t = (cnt == 5'd0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jtag_clk_gen.sv
// tclk divider: toggles tclk every CLK_DIV clk cycles while enabled and
// emits one-clk strobes on the cycle whose edge raises or lowers tclk.
module jtag_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] divCnt_q, divCnt_d;
  logic             tclk_q, tclk_d;
  logic             wrap;

  // Count out each half-period; dropping enable parks tclk low immediately.
  always_comb begin
    wrap     = en_i && (divCnt_q == CNT_W'(CLK_DIV - 1));
    divCnt_d = divCnt_q;
    tclk_d   = tclk_q;
    if (!en_i) begin
      divCnt_d = '0;
      tclk_d   = 1'b0;
    end else if (wrap) begin
      divCnt_d = '0;
      tclk_d   = ~tclk_q;
    end else begin
      divCnt_d = divCnt_q + 1'b1;
    end
  end

  // Divider registers, cleared with tclk low on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q <= '0;
      tclk_q   <= 1'b0;
    end else begin
      divCnt_q <= divCnt_d;
      tclk_q   <= tclk_d;
    end
  end

  assign tclk_o      = tclk_q;
  assign rise_tick_o = wrap && !tclk_q;
  assign fall_tick_o = wrap && tclk_q;

endmodule

// File: rtl/jtag_master.sv
// System-clock JTAG initiator: runs one RESET / IR scan / DR scan / idle
// command at a time and returns the captured TDO bits.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_len_m1,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tclk,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trst
);

  jtag_mstate_t       state_q, state_d;
  logic [4:0]         bitCnt_q, bitCnt_d;
  jtag_cmd_op_t       op_q, op_d;
  logic [4:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] capture_q, capture_d;
  logic [MAX_LEN-1:0] rspData_q, rspData_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q;
  jtag_state_t        shadow_q, shadow_d;
  logic               launch;
  logic               clkEn;
  logic               riseTick;
  logic               fallTick;

  assign clkEn = (state_q == M_INIT) || (state_q == M_HDR) ||
                 (state_q == M_SHIFT) || (state_q == M_TRL);

  jtag_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (clkEn),
    .tclk_o     (tclk),
    .rise_tick_o(riseTick),
    .fall_tick_o(fallTick)
  );

  // Next-state logic: bits advance on tclk falls, TDO is captured on rises,
  // and tms/tdi for the next bit are launched whenever the position moves.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    op_d      = op_q;
    len_d     = len_q;
    data_d    = data_q;
    capture_d = capture_q;
    rspData_d = rspData_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    shadow_d  = shadow_q;
    launch    = 1'b0;

    if (riseTick) begin
      shadow_d = jtag_next_state(shadow_q, tms_q);
      if (state_q == M_SHIFT && op_q != OP_RUN_IDLE) begin
        capture_d[bitCnt_q] = tdo;
      end
    end

    case (state_q)
      M_INIT: begin
        if (fallTick) begin
          launch = 1'b1;
          if (bitCnt_q == RESET_LAST_BIT) begin
            state_d  = M_IDLE;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      M_IDLE: begin
        if (cmd_valid) begin
          op_d      = jtag_cmd_op_t'(cmd_op);
          len_d     = cmd_len_m1;
          data_d    = cmd_data;
          capture_d = '0;
          bitCnt_d  = '0;
          state_d   = (op_d == OP_RUN_IDLE) ? M_SHIFT : M_HDR;
          launch    = 1'b1;
        end
      end
      M_HDR: begin
        if (fallTick) begin
          launch = 1'b1;
          if (bitCnt_q == jtag_hdr_last(op_q)) begin
            bitCnt_d = '0;
            if (op_q == OP_RESET) begin
              state_d   = M_DONE;
              rspData_d = capture_q;
            end else begin
              state_d = M_SHIFT;
            end
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      M_SHIFT: begin
        if (fallTick) begin
          launch = 1'b1;
          if (bitCnt_q == len_q) begin
            bitCnt_d = '0;
            if (op_q == OP_RUN_IDLE) begin
              state_d   = M_DONE;
              rspData_d = capture_q;
            end else begin
              state_d = M_TRL;
            end
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      M_TRL: begin
        if (fallTick) begin
          launch = 1'b1;
          if (bitCnt_q == 5'd1) begin
            bitCnt_d  = '0;
            state_d   = M_DONE;
            rspData_d = capture_q;
          end else begin
            bitCnt_d = bitCnt_q + 5'd1;
          end
        end
      end
      M_DONE: begin
        state_d = M_IDLE;
      end
      default: begin
        state_d = M_INIT;
      end
    endcase

    if (launch) begin
      tms_d = jtag_pos_tms(state_d, bitCnt_d, op_d, len_d);
      tdi_d = (state_d == M_SHIFT && op_d != OP_RUN_IDLE) ? data_d[bitCnt_d] : 1'b0;
    end
  end

  // FSM state and bit position; reset restarts the autonomous TAP reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= M_INIT;
      bitCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
    end
  end

  // Command latch, capture, response and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_RESET;
      len_q     <= '0;
      data_q    <= '0;
      capture_q <= '0;
      rspData_q <= '0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trst_q    <= 1'b0;
      shadow_q  <= TEST_LOGIC_RESET;
    end else begin
      op_q      <= op_d;
      len_q     <= len_d;
      data_q    <= data_d;
      capture_q <= capture_d;
      rspData_q <= rspData_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      trst_q    <= 1'b1;
      shadow_q  <= shadow_d;
    end
  end

  assign cmd_ready = (state_q == M_IDLE);
  assign rsp_valid = (state_q == M_DONE);
  assign rsp_data  = rspData_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst      = trst_q;

  // Every command leaves the TAP parked in Run-Test/Idle.
  idleInRti: assert property (@(posedge clk) disable iff (rst)
    cmd_ready |-> (shadow_q == RUN_TEST_IDLE));

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a small behavioural TAP (IDCODE and
// bypass data registers, 6-bit IR) hanging off the JTAG pins.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 2000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [4:0]         cmd_len_m1 = 5'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tclk;
  logic               tms;
  logic               tdi;
  logic               tdo;
  logic               trst;

  int total = 0;
  int bad   = 0;

  int riseCount   = 0;
  int rspCount    = 0;
  int acceptCount = 0;
  int lastBase    = 0;
  logic tclkPrev  = 1'b0;
  bit   tmsLog [0:1023];

  always #5 clk = ~clk;

  jtag_master #(
    .CLK_DIV(CLK_DIV),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len_m1(cmd_len_m1),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tclk      (tclk),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .trst      (trst)
  );

  // Behavioural TAP
  jtag_state_t tapState;
  logic [5:0]  irSr;
  logic [5:0]  irReg;
  logic [31:0] drSr;
  logic        bypassBit;

  always @(posedge tclk or negedge trst) begin
    if (!trst) begin
      tapState  <= TEST_LOGIC_RESET;
      irReg     <= IR_IDCODE;
      irSr      <= 6'h0;
      drSr      <= 32'h0;
      bypassBit <= 1'b0;
    end else begin
      case (tapState)
        TEST_LOGIC_RESET: irReg <= IR_IDCODE;
        CAPTURE_IR:       irSr  <= 6'b000001;
        SHIFT_IR:         irSr  <= {tdi, irSr[5:1]};
        UPDATE_IR:        irReg <= irSr;
        CAPTURE_DR: begin
          if (irReg == IR_IDCODE) drSr <= IDCODE_VALUE;
          else                    bypassBit <= 1'b0;
        end
        SHIFT_DR: begin
          if (irReg == IR_IDCODE) drSr <= {tdi, drSr[31:1]};
          else                    bypassBit <= tdi;
        end
        default: ;
      endcase
      tapState <= jtag_next_state(tapState, tms);
    end
  end

  always @(negedge tclk or negedge trst) begin
    if (!trst)                    tdo <= 1'b0;
    else if (tapState == SHIFT_IR) tdo <= irSr[0];
    else if (tapState == SHIFT_DR) tdo <= (irReg == IR_IDCODE) ? drSr[0] : bypassBit;
    else                          tdo <= 1'b0;
  end

  // Pin monitor: tclk rises with their tms value and response pulses
  always @(negedge clk) begin
    if (tclk === 1'b1 && tclkPrev === 1'b0) begin
      if (riseCount < 1024) tmsLog[riseCount] = tms;
      riseCount++;
    end
    tclkPrev = tclk;
    if (rsp_valid === 1'b1) rspCount++;
  end

  // Handshake monitor
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready === 1'b1) acceptCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] tmsPattern(input int base, input int n);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i] = tmsLog[base + i];
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitRsp(output bit ok, output logic [MAX_LEN-1:0] data);
    ok   = 1'b0;
    data = '0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin
        ok   = 1'b1;
        data = rsp_data;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [4:0] lenM1,
                               input logic [MAX_LEN-1:0] data, input logic [MAX_LEN-1:0] expRsp,
                               input int expRises);
    bit ok;
    logic [MAX_LEN-1:0] rsp;
    int rspBase;
    waitReady(ok);
    checkOutput({tag, "Ready"}, ok, 1);
    if (!ok) return;
    lastBase   = riseCount;
    rspBase    = rspCount;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_len_m1 = lenM1;
    cmd_data   = data;
    tick();
    cmd_valid  = 1'b0;
    waitRsp(ok, rsp);
    checkOutput({tag, "RspSeen"}, ok, 1);
    checkOutput({tag, "Rsp"}, rsp, expRsp);
    checkOutput({tag, "Rises"}, riseCount - lastBase, expRises);
    repeat (3) tick();
    checkOutput({tag, "RspPulses"}, rspCount - rspBase, 1);
    checkOutput({tag, "TapRti"}, tapState, RUN_TEST_IDLE);
  endtask

  initial begin
    bit ok;
    int base;
    int base2;
    int rspBase;
    int accBase;
    logic [MAX_LEN-1:0] rsp;

    $display("[TB] start");
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("resetPins", {tclk, tms, tdi, trst, cmd_ready, rsp_valid}, 6'b010000);
    checkOutput("resetRspData", rsp_data, 0);

    // Power-up: autonomous reset sequence
    base    = riseCount;
    rspBase = rspCount;
    rst     = 1'b0;
    tick();
    checkOutput("trstRelease", trst, 1);
    waitReady(ok);
    checkOutput("initReady", ok, 1);
    checkOutput("initRises", riseCount - base, 6);
    checkOutput("initTms", tmsPattern(base, 6), 6'b011111);
    checkOutput("initTap", tapState, RUN_TEST_IDLE);
    checkOutput("initNoRsp", rspCount - rspBase, 0);

    // IDCODE read after TAP reset
    applyStimulus("idcode", OP_DR_SCAN, 5'd31, '0, IDCODE_VALUE, 37);

    // Load BYPASS, then shift 4 bits through the 1-bit bypass register
    applyStimulus("irBypass", OP_IR_SCAN, 5'd5, 32'h3F, 32'h01, 12);
    applyStimulus("drBypass", OP_DR_SCAN, 5'd3, 32'hB, 32'h6, 9);

    // 1-bit IR scan: the only shift bit carries tms=1
    applyStimulus("ir1bit", OP_IR_SCAN, 5'd0, 32'h1, 32'h1, 7);
    checkOutput("ir1bitTms", tmsPattern(lastBase, 7), 7'b0110011);

    // Busy: second command held on the bus while the first one runs
    waitReady(ok);
    checkOutput("busyReady", ok, 1);
    base       = riseCount;
    accBase    = acceptCount;
    cmd_valid  = 1'b1;
    cmd_op     = OP_DR_SCAN;
    cmd_len_m1 = 5'd7;
    cmd_data   = 32'hA5;
    tick();
    cmd_op     = OP_RUN_IDLE;
    cmd_len_m1 = 5'd9;
    cmd_data   = '0;
    waitRsp(ok, rsp);
    checkOutput("busyRspSeen", ok, 1);
    checkOutput("busyRsp", rsp, 32'h4A);
    checkOutput("busyRises", riseCount - base, 13);
    checkOutput("busyAccepts", acceptCount - accBase, 1);
    waitReady(ok);
    base2 = riseCount;
    tick();
    cmd_valid = 1'b0;
    waitRsp(ok, rsp);
    checkOutput("idleRspSeen", ok, 1);
    checkOutput("idleRsp", rsp, 0);
    checkOutput("idleRises", riseCount - base2, 10);
    checkOutput("idleTms", tmsPattern(base2, 10), 0);
    checkOutput("idleAccepts", acceptCount - accBase, 2);

    // Explicit RESET command (also selects IDCODE again)
    applyStimulus("rstOp", OP_RESET, 5'd0, 32'hFFFF_FFFF, 32'h0, 6);
    checkOutput("rstOpTms", tmsPattern(lastBase, 6), 6'b011111);

    // Abort a 32-bit DR scan in the high half of shift bit 10
    waitReady(ok);
    base       = riseCount;
    rspBase    = rspCount;
    cmd_valid  = 1'b1;
    cmd_op     = OP_DR_SCAN;
    cmd_len_m1 = 5'd31;
    cmd_data   = '0;
    tick();
    cmd_valid  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (riseCount - base >= 14) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("midReach", ok, 1);
    rst = 1'b1;
    tick();
    checkOutput("midAbortPins", {tclk, tms, trst, cmd_ready, rsp_valid}, 5'b01000);
    checkOutput("midTapReset", tapState, TEST_LOGIC_RESET);
    repeat (2) tick();
    base = riseCount;
    rst  = 1'b0;
    waitReady(ok);
    checkOutput("midInitReady", ok, 1);
    checkOutput("midInitRises", riseCount - base, 6);
    checkOutput("midInitTms", tmsPattern(base, 6), 6'b011111);
    checkOutput("midNoRsp", rspCount - rspBase, 0);
    applyStimulus("idcode2", OP_DR_SCAN, 5'd31, '0, IDCODE_VALUE, 37);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- System-clock-domain JTAG initiator that drives `tclk`/`tms`/`tdi`/`trst` into the debug TAP (`dtm_jtag`) and samples `tdo`.
- Accepts one command at a time over a valid/ready handshake: TAP reset, IR scan, DR scan, or idle clocks.
- Returns the captured shift-out data. Used by the boot/test sequencer and by the board-level bench that drives the debug port.

Parameters:
- CLK_DIV, 2, `clk` cycles per tclk half-period (≥1); tclk period = 2*CLK_DIV clk cycles.
- MAX_LEN, 32, maximum scan length in bits; sets the width of cmd_data and rsp_data.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  master idle, command accepted when valid&ready
- cmd_op  input  2  0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=RUN_IDLE
- cmd_len_m1  input  5  scan length minus 1 (1..32 bits); for RUN_IDLE, idle tclk count minus 1
- cmd_data  input  MAX_LEN  TDI bits; bit 0 shifted first
- rsp_valid  output  1  one-clk pulse when a command completes
- rsp_data  output  MAX_LEN  captured TDO; bit i = i-th sampled bit, bits ≥ len are 0; held until the next completion
- tclk  output  1  JTAG clock to the TAP
- tms  output  1  mode select
- tdi  output  1  serial data to the TAP
- tdo  input  1  serial data from the TAP
- trst  output  1  active-low TAP reset

Behaviour:
- Reset (rst=1) values:
  - tclk=0, tms=1, tdi=0, trst=0
  - cmd_ready=0, rsp_valid=0, rsp_data=0
- After rst deasserts:
  - trst=1 from the first clk.
  - The master autonomously runs the RESET sequence, then raises cmd_ready.
- Bit timing:
  - One "bit" = one tclk low half plus one high half.
  - tms/tdi change only on the clk where tclk falls (or at the start of a low half).
  - tdo is sampled on the clk where tclk rises. The TAP updates tdo on its negedge, so it is stable at the master's rising edge.
  - tclk idles low between commands.
- Master FSM states: M_INIT, M_IDLE, M_HDR, M_SHIFT, M_TRL, M_DONE.
  - M_IDLE: cmd_ready=1. On handshake, latch op/len/data, clear the capture register, go to M_HDR.
  - RESET: 5 bits tms=1 then 1 bit tms=0 → TAP ends in RUN_TEST_IDLE; rsp_data=0.
  - DR_SCAN header: tms 1,0,0 (RTI→SELECT_DR→CAPTURE_DR→SHIFT_DR).
  - IR_SCAN header: tms 1,1,0,0 (RTI→SELECT_DR→SELECT_IR→CAPTURE_IR→SHIFT_IR).
  - M_SHIFT: len bits. tdi=cmd_data[k]; tms=0 except the last bit, where tms=1 (→EXIT1). tdo is sampled into capture[k] on every shift bit, including the last.
  - M_TRL: tms 1,0 (EXIT1→UPDATE→RTI).
  - RUN_IDLE: len bits with tms=0, tdi=0; rsp_data=0.
  - M_DONE: drive rsp_valid=1 for one clk and update rsp_data, then go to M_IDLE.
- Total tclk rising edges per command:
  - RESET = 6
  - DR_SCAN = len+5
  - IR_SCAN = len+6
  - RUN_IDLE = len
- The master keeps a shadow jtag_state_t, advanced on each tclk rise using the same transition table as the TAP. It must equal RUN_TEST_IDLE whenever cmd_ready=1 (assertion).
- cmd_valid while busy: ignored; cmd_ready stays 0. The command is held by the requester.
- rsp_valid and cmd_ready can be high on consecutive clks only: M_DONE precedes M_IDLE.
- rst mid-command:
  - Abort immediately to the reset values, with tclk forced low.
  - No rsp_valid is issued for the aborted command.
  - The INIT RESET sequence reruns after release.
- Length boundaries:
  - cmd_len_m1=0 gives a 1-bit scan: the only shift bit has tms=1.
  - cmd_len_m1=31 uses all of cmd_data.
- Divider counter wraps at CLK_DIV-1. Each wrap toggles tclk.

Decomposition:
- Package jtag: reuse jtag_state_t. Add:
  - jtag_cmd_op_t enum
  - shared function jtag_next_state(state, tms), which dtm_jtag also adopts
  - IR opcode constants BYPASS=6'h3F, IDCODE=6'h01, DMI=6'h21, SAMPLE=6'h00
  - IDCODE_VALUE=32'h1BEEF001
- Sub-module jtag_clk_gen: divider producing tclk plus single-clk rise_tick/fall_tick strobes. The master FSM consumes only these strobes.

Test Plan:
- Power-up: rst released → 6 tclk rises, tms=1,1,1,1,1,0, then cmd_ready=1. Bench-side dtm_jtag reaches RUN_TEST_IDLE.
- IDCODE: DR_SCAN len_m1=31, data=0 → rsp_data=32'h1BEEF001; 37 tclk rises; one rsp_valid pulse.
- IR load: IR_SCAN len_m1=5, data=6'h3F → rsp_data=6'b000001 (capture value). Then DR_SCAN len_m1=3, data=4'b1011 → rsp_data=4'b0110 (1-bit bypass delay).
- 1-bit scan: IR_SCAN len_m1=0, data=1 → tms sequence 1,1,0,0,1,1,0; rsp_data=1; shadow state RUN_TEST_IDLE.
- Busy/handshake: assert cmd_valid continuously with a new command during a scan → no second accept until cmd_ready. RUN_IDLE len_m1=9 → exactly 10 tclk rises with tms=0.
- Mid-scan reset: assert rst during SHIFT_DR bit 10 of a 32-bit scan → next clk tclk=0, trst=0, no rsp_valid. After release, the INIT sequence runs, then IDCODE reads 32'h1BEEF001.
